riscoffee_wb_arbiter: RTL and testbench
=======================================

// Module: riscoffee_wb_arbiter
// PURPOSE
//  Sole writer of the register-file write port (MA_RD_NUM/WEN/WDATA). Merges the in-order
//  MA-stage result with results from long-latency units (mul/div, loads) via a small FIFO.
//  Keeps a 32-bit pending-write scoreboard that issue logic checks for RAW/WAW stalls.
//  Sits between the MA stage / LL units and the regfile; outputs are registered.
// PARAMETERS
//  DEPTH         4  LL result FIFO entries; power of two, >=2
//  STARVE_LIMIT  8  consecutive cycles the FIFO head may wait before the pipe is stalled
// PORTS
//  CLK          in   1   clock
//  RST_N        in   1   reset, synchronous, active-low
//  PIPE_VALID   in   1   MA-stage result valid (no ready; accepted unless PIPE_STALL)
//  PIPE_RD_NUM  in   5   MA-stage destination
//  PIPE_DATA    in   32  MA-stage result
//  PIPE_STALL   out  1   combinational; pipe must hold MA contents this cycle
//  LL_VALID     in   1   long-latency result valid
//  LL_READY     out  1   FIFO can accept (= !full)
//  LL_RD_NUM    in   5   LL destination
//  LL_DATA      in   32  LL result
//  ISSUE_VALID  in   1   LL op issued this cycle
//  ISSUE_RD_NUM in   5   its destination
//  BUSY         out  32  registered scoreboard, bit i = LL write to xi pending
//  MA_RD_NUM    out  5   regfile write index
//  WEN          out  1   regfile write enable
//  WDATA        out  32  regfile write data
// BEHAVIOUR
//  Reset: MA_RD_NUM=0, WEN=0, WDATA=0, BUSY=0, FIFO empty, starve counter=0, LL_READY=1
//   next cycle; reset mid-operation discards FIFO contents and pending bits.
//  LL accept: LL_VALID&&LL_READY at edge -> push {rd,data}. LL_READY from count only; full
//   FIFO with simultaneous pop still shows LL_READY=0 (no pass-through).
//  Selection per cycle (combinational, registered into outputs at next edge):
//   1. starve_cnt==STARVE_LIMIT and FIFO non-empty: PIPE_STALL=1, pop head, PIPE_VALID ignored
//   2. PIPE_VALID && PIPE_RD_NUM!=0: pipe wins; FIFO waits, starve_cnt++ if non-empty
//   3. FIFO non-empty: pop head
//   4. else idle: WEN<=0
//  starve_cnt clears on every pop or when FIFO empty; saturates at STARVE_LIMIT.
//  rd==0: pipe with rd 0 counts as idle (FIFO may pop); FIFO entry with rd 0 popped, WEN<=0.
//  Output: WEN<=1 iff selected rd!=0; MA_RD_NUM/WDATA<=selected rd/data; on idle hold old
//   MA_RD_NUM/WDATA, WEN<=0.
//  Latency: PIPE_VALID cycle N -> WEN high cycle N+1. LL handshake cycle N, FIFO empty, pipe
//   idle -> WEN high cycle N+2. FIFO order strictly preserved.
//  Scoreboard: ISSUE_VALID && rd!=0 sets BUSY[rd]; popping an LL entry with rd!=0 clears
//   BUSY[rd]; set and clear of same bit same cycle -> set wins. BUSY[0] always 0.
//  Illegal (SVA in bench, no RTL handling): ISSUE to already-busy rd; PIPE_VALID with
//   rd busy; LL result for a non-busy rd; LL_VALID dropped before handshake.
// STRUCTURE
//  riscoffee_pkg: XLEN=32, REG_NUM_W=5, typedef struct packed {logic[4:0] rd;
//   logic[31:0] data;} wb_req_t; enum {SEL_IDLE,SEL_PIPE,SEL_LL} wb_sel_e.
//  Sub-module riscoffee_wb_fifo: DEPTH-entry sync FIFO of wb_req_t, push/pop/full/empty/
//   count, ptr wrap via extra MSB. Arbiter, starve counter, scoreboard stay in this module.
// TESTING
//  Pipe only: PIPE_VALID rd=5 data=0xDEADBEEF -> next cycle WEN=1, MA_RD_NUM=5, WDATA=0xDEADBEEF.
//  Issue rd=7, LL result rd=7 data=0x1234 idle pipe -> BUSY[7]=1 then WEN=1 rd=7 two cycles
//   after handshake, BUSY[7]=0 same edge.
//  Conflict: LL entry queued, PIPE_VALID every cycle -> after 8 waiting cycles PIPE_STALL=1
//   one cycle, LL entry written, pipe resumes next cycle; no pipe result lost.
//  Fill: 4 LL results while pipe busy -> LL_READY=0 on 5th; drain order rd 1,2,3,4.
//  rd 0: pipe rd=0 with FIFO non-empty -> FIFO pops same cycle; LL rd=0 -> WEN stays 0.
//  Reset mid-run with 3 queued and BUSY=0x88 -> next cycle WEN=0, BUSY=0, LL_READY=1.

Source files
------------

// File: rtl/riscoffee_pkg.sv
// Shared types for the riscoffee write-back path.
//   XLEN       - datapath width
//   REG_NUM_W  - register index width
//   wb_req_t   - one pending register-file write {rd, data}
//   wb_sel_e   - write-back source chosen for a cycle
package riscoffee_pkg;

    localparam int XLEN      = 32;
    localparam int REG_NUM_W = 5;

    typedef struct packed {
        logic [REG_NUM_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_req_t;

    typedef enum logic [1:0] {
        SEL_IDLE,
        SEL_PIPE,
        SEL_LL
    } wb_sel_e;

endpackage

// File: rtl/riscoffee_wb_fifo.sv
// Synchronous FIFO holding long-latency write-back requests.
//   CLK, RST_N  - clock, synchronous active-low reset (empties the FIFO)
//   push        - write push_req (ignored when full)
//   push_req    - request to enqueue
//   pop         - drop the head entry (ignored when empty)
//   head        - current head entry
//   full, empty - occupancy flags
//   count       - number of stored entries
// Pointers carry one extra MSB so full and empty are told apart without
// a separate flag.
module riscoffee_wb_fifo
    import riscoffee_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       push,
    input  wb_req_t                    push_req,
    input  logic                       pop,
    output wb_req_t                    head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    wb_req_t     mem [DEPTH];

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge CLK) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_req;
    end

endmodule

// File: rtl/riscoffee_wb_arbiter.sv
// Register-file write-back arbiter: sole writer of the regfile write port.
//   CLK, RST_N                          - clock, synchronous active-low reset
//   PIPE_VALID/PIPE_RD_NUM/PIPE_DATA    - in-order MA-stage result (no ready)
//   PIPE_STALL                          - MA stage must hold its result this cycle
//   LL_VALID/LL_RD_NUM/LL_DATA/LL_READY - long-latency result handshake
//   ISSUE_VALID/ISSUE_RD_NUM            - LL op issued; marks rd pending
//   BUSY                                - pending LL write per register
//   MA_RD_NUM/WEN/WDATA                 - registered regfile write port
// The pipe normally wins; a queued LL result that has waited STARVE_LIMIT
// cycles forces a one-cycle pipe stall so it can drain.
module riscoffee_wb_arbiter
    import riscoffee_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 PIPE_VALID,
    input  logic [REG_NUM_W-1:0] PIPE_RD_NUM,
    input  logic [XLEN-1:0]      PIPE_DATA,
    output logic                 PIPE_STALL,
    input  logic                 LL_VALID,
    output logic                 LL_READY,
    input  logic [REG_NUM_W-1:0] LL_RD_NUM,
    input  logic [XLEN-1:0]      LL_DATA,
    input  logic                 ISSUE_VALID,
    input  logic [REG_NUM_W-1:0] ISSUE_RD_NUM,
    output logic [XLEN-1:0]      BUSY,
    output logic [REG_NUM_W-1:0] MA_RD_NUM,
    output logic                 WEN,
    output logic [XLEN-1:0]      WDATA
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    wb_req_t         head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic            push;
    logic            pop;
    wb_sel_e         sel;
    logic [SW-1:0]   starve_cnt;
    logic [XLEN-1:0] busy_nxt;

    riscoffee_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .push     (push),
        .push_req ('{rd: LL_RD_NUM, data: LL_DATA}),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Ready depends only on occupancy: a full FIFO stays not-ready even
    // when it is being popped in the same cycle.
    assign LL_READY = (fifo_count != CW'(DEPTH));
    assign push     = LL_VALID && !fifo_full;

    always_comb begin
        sel        = SEL_IDLE;
        PIPE_STALL = 1'b0;
        if (starve_cnt == SW'(STARVE_LIMIT) && !fifo_empty) begin
            sel        = SEL_LL;
            PIPE_STALL = 1'b1;
        end else if (PIPE_VALID && PIPE_RD_NUM != '0) begin
            sel = SEL_PIPE;
        end else if (!fifo_empty) begin
            sel = SEL_LL;
        end
    end

    assign pop = (sel == SEL_LL);

    // Set is applied after clear so an issue wins over a same-cycle retire.
    always_comb begin
        busy_nxt = BUSY;
        if (pop && head.rd != '0)
            busy_nxt[head.rd] = 1'b0;
        if (ISSUE_VALID && ISSUE_RD_NUM != '0)
            busy_nxt[ISSUE_RD_NUM] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            starve_cnt <= '0;
            BUSY       <= '0;
            MA_RD_NUM  <= '0;
            WEN        <= 1'b0;
            WDATA      <= '0;
        end else begin
            BUSY <= busy_nxt;

            if (pop || fifo_empty)
                starve_cnt <= '0;
            else if (sel == SEL_PIPE && starve_cnt != SW'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + 1'b1;

            case (sel)
                SEL_PIPE: begin
                    MA_RD_NUM <= PIPE_RD_NUM;
                    WDATA     <= PIPE_DATA;
                    WEN       <= 1'b1;
                end
                SEL_LL: begin
                    MA_RD_NUM <= head.rd;
                    WDATA     <= head.data;
                    WEN       <= (head.rd != '0);
                end
                default: WEN <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_riscoffee_wb_arbiter.sv
// Self-checking bench for riscoffee_wb_arbiter: directed scenarios plus
// constrained-random traffic compared against a queue-based reference model.
module tb_riscoffee_wb_arbiter;
    import riscoffee_pkg::*;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        PIPE_VALID, LL_VALID, ISSUE_VALID;
    logic [4:0]  PIPE_RD_NUM, LL_RD_NUM, ISSUE_RD_NUM;
    logic [31:0] PIPE_DATA, LL_DATA;
    logic        PIPE_STALL, LL_READY, WEN;
    logic [31:0] BUSY, WDATA;
    logic [4:0]  MA_RD_NUM;

    always #5 CLK = ~CLK;

    riscoffee_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .PIPE_VALID(PIPE_VALID), .PIPE_RD_NUM(PIPE_RD_NUM), .PIPE_DATA(PIPE_DATA),
        .PIPE_STALL(PIPE_STALL),
        .LL_VALID(LL_VALID), .LL_READY(LL_READY), .LL_RD_NUM(LL_RD_NUM), .LL_DATA(LL_DATA),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_RD_NUM(ISSUE_RD_NUM),
        .BUSY(BUSY), .MA_RD_NUM(MA_RD_NUM), .WEN(WEN), .WDATA(WDATA)
    );

    // Stimulus legality rules
    a_issue_free: assert property (@(posedge CLK) disable iff (!RST_N)
        ISSUE_VALID && ISSUE_RD_NUM != 0 |-> !BUSY[ISSUE_RD_NUM]);
    a_pipe_free: assert property (@(posedge CLK) disable iff (!RST_N)
        PIPE_VALID && PIPE_RD_NUM != 0 |-> !BUSY[PIPE_RD_NUM]);
    a_ll_busy: assert property (@(posedge CLK) disable iff (!RST_N)
        LL_VALID && LL_RD_NUM != 0 |-> BUSY[LL_RD_NUM]);
    a_ll_hold: assert property (@(posedge CLK) disable iff (!RST_N)
        LL_VALID && !LL_READY |=> LL_VALID && $stable(LL_RD_NUM) && $stable(LL_DATA));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference model state
    wb_req_t     mq[$];
    int          m_starve;
    logic [31:0] m_busy;
    logic        m_wen;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic        m_stall, m_ready, last_hs, dut_stall;

    task automatic model_reset();
        mq.delete();
        m_starve = 0; m_busy = '0; m_wen = 1'b0; m_rd = '0; m_data = '0;
    endtask

    task automatic model_update();
        wb_req_t h;
        bit pop = 0;
        bit nonempty = (mq.size() > 0);
        bit push = LL_VALID && m_ready;
        if (!RST_N) begin
            model_reset();
            return;
        end
        if (m_stall) pop = 1;
        else if (PIPE_VALID && PIPE_RD_NUM != 0) begin
            m_wen = 1'b1; m_rd = PIPE_RD_NUM; m_data = PIPE_DATA;
        end else if (nonempty) pop = 1;
        else m_wen = 1'b0;
        if (pop) begin
            h = mq.pop_front();
            m_wen = (h.rd != 0); m_rd = h.rd; m_data = h.data;
            if (h.rd != 0) m_busy[h.rd] = 1'b0;
        end
        if (pop || !nonempty) m_starve = 0;
        else if (m_starve < LIMIT) m_starve++;
        if (ISSUE_VALID && ISSUE_RD_NUM != 0) m_busy[ISSUE_RD_NUM] = 1'b1;
        if (push) mq.push_back('{rd: LL_RD_NUM, data: LL_DATA});
    endtask

    // One clock: check combinational outputs mid-cycle, advance the model,
    // then check registered outputs just after the edge.
    task automatic tick();
        @(negedge CLK);
        m_ready   = (mq.size() < DEPTH);
        m_stall   = (m_starve == LIMIT) && (mq.size() > 0);
        last_hs   = LL_VALID && m_ready;
        dut_stall = PIPE_STALL;
        check("ll_ready", LL_READY, m_ready);
        check("pipe_stall", PIPE_STALL, m_stall);
        model_update();
        @(posedge CLK);
        #1;
        check("wen", WEN, m_wen);
        check("ma_rd_num", MA_RD_NUM, m_rd);
        check("wdata", WDATA, m_data);
        check("busy", BUSY, m_busy);
    endtask

    task automatic idle_inputs();
        PIPE_VALID = 0; LL_VALID = 0; ISSUE_VALID = 0;
        PIPE_RD_NUM = '0; LL_RD_NUM = '0; ISSUE_RD_NUM = '0;
        PIPE_DATA = '0; LL_DATA = '0;
    endtask

    logic [4:0] pend_ret[$];
    logic [4:0] drained[$];

    initial begin
        int stall_cnt, stall_at, seq;
        bit pipe_hold;
        logic [4:0] r;

        idle_inputs();
        RST_N = 0;
        repeat (2) @(posedge CLK);
        #1;
        model_reset();

        // Reset state
        tick();
        check("rst_wen", WEN, 0);
        check("rst_busy", BUSY, 0);
        check("rst_ll_ready", LL_READY, 1);
        RST_N = 1;
        tick();

        // Pipe only
        PIPE_VALID = 1; PIPE_RD_NUM = 5; PIPE_DATA = 32'hDEADBEEF;
        tick();
        check("pipe_wen", WEN, 1);
        check("pipe_rd", MA_RD_NUM, 5);
        check("pipe_data", WDATA, 32'hDEADBEEF);
        idle_inputs();
        tick();
        check("pipe_idle_wen", WEN, 0);

        // Issue then LL result with idle pipe: write two cycles after handshake
        ISSUE_VALID = 1; ISSUE_RD_NUM = 7;
        tick();
        idle_inputs();
        check("issue_busy7", BUSY[7], 1);
        LL_VALID = 1; LL_RD_NUM = 7; LL_DATA = 32'h1234;
        tick();
        idle_inputs();
        check("ll_lat_n1_wen", WEN, 0);
        tick();
        check("ll_lat_wen", WEN, 1);
        check("ll_lat_rd", MA_RD_NUM, 7);
        check("ll_lat_data", WDATA, 32'h1234);
        check("ll_busy7_clr", BUSY[7], 0);

        // Starvation: pipe busy every cycle with one LL entry queued
        ISSUE_VALID = 1; ISSUE_RD_NUM = 9;
        tick();
        idle_inputs();
        stall_cnt = 0; stall_at = -1; seq = 0;
        for (int i = 0; i < 14; i++) begin
            PIPE_VALID = 1; PIPE_RD_NUM = 10; PIPE_DATA = 32'h100 + seq;
            if (i == 0) begin LL_VALID = 1; LL_RD_NUM = 9; LL_DATA = 32'h99; end
            tick();
            if (last_hs) LL_VALID = 0;
            if (dut_stall) begin
                stall_cnt++;
                if (stall_at < 0) stall_at = i;
            end else seq++;
            if (i == 9) check("starve_ll_rd", MA_RD_NUM, 9);
            if (i == 10) check("starve_resume_data", WDATA, 32'h109);
        end
        check("starve_stall_cnt", stall_cnt, 1);
        check("starve_stall_at", stall_at, 9);
        idle_inputs();
        tick();

        // Fill the FIFO behind a busy pipe, then drain in order
        for (int i = 1; i <= 4; i++) begin
            ISSUE_VALID = 1; ISSUE_RD_NUM = 5'(i);
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            PIPE_VALID = 1; PIPE_RD_NUM = 20; PIPE_DATA = 32'h200 + i;
            LL_VALID = (i < 4); LL_RD_NUM = 5'(i + 1); LL_DATA = 32'hA0 + i;
            if (i == 4) check("fill_not_ready", LL_READY, 0);
            tick();
        end
        idle_inputs();
        drained.delete();
        for (int i = 0; i < 8; i++) begin
            tick();
            if (WEN && MA_RD_NUM >= 1 && MA_RD_NUM <= 4) drained.push_back(MA_RD_NUM);
        end
        check("fill_drain_cnt", drained.size(), 4);
        for (int i = 0; i < drained.size(); i++) check("fill_drain_order", drained[i], i + 1);

        // rd 0 handling
        ISSUE_VALID = 1; ISSUE_RD_NUM = 11;
        tick();
        idle_inputs();
        LL_VALID = 1; LL_RD_NUM = 11; LL_DATA = 32'hB0B;
        tick();
        idle_inputs();
        PIPE_VALID = 1; PIPE_RD_NUM = 0; PIPE_DATA = 32'hFFFF;
        tick();
        check("rd0_pipe_pop_wen", WEN, 1);
        check("rd0_pipe_pop_rd", MA_RD_NUM, 11);
        check("rd0_pipe_pop_data", WDATA, 32'hB0B);
        idle_inputs();
        LL_VALID = 1; LL_RD_NUM = 0; LL_DATA = 32'hCAFE;
        tick();
        idle_inputs();
        tick();
        check("rd0_ll_wen", WEN, 0);

        // Constrained-random traffic
        pend_ret.delete();
        pipe_hold = 0;
        for (int n = 0; n < 600; n++) begin
            if (!pipe_hold) begin
                PIPE_VALID = ($urandom_range(0, 99) < 60);
                r = 5'($urandom_range(0, 31));
                for (int k = 0; k < 64 && m_busy[r]; k++) r = 5'($urandom_range(0, 31));
                if (m_busy[r]) PIPE_VALID = 0;
                PIPE_RD_NUM = r;
                PIPE_DATA = $urandom;
            end
            if (!LL_VALID) begin
                if (pend_ret.size() > 0 && $urandom_range(0, 99) < 40) begin
                    int idx = $urandom_range(0, pend_ret.size() - 1);
                    LL_RD_NUM = pend_ret[idx];
                    pend_ret.delete(idx);
                    LL_VALID = 1; LL_DATA = $urandom;
                end else if ($urandom_range(0, 99) < 4) begin
                    LL_RD_NUM = 0; LL_VALID = 1; LL_DATA = $urandom;
                end
            end
            ISSUE_VALID = ($urandom_range(0, 99) < 30);
            r = 5'($urandom_range(0, 31));
            for (int k = 0; k < 64 && (m_busy[r] || (PIPE_VALID && r == PIPE_RD_NUM && r != 0)); k++)
                r = 5'($urandom_range(0, 31));
            if (m_busy[r] || (PIPE_VALID && r == PIPE_RD_NUM && r != 0)) ISSUE_VALID = 0;
            ISSUE_RD_NUM = r;
            tick();
            if (last_hs) LL_VALID = 0;
            if (ISSUE_VALID && ISSUE_RD_NUM != 0) pend_ret.push_back(ISSUE_RD_NUM);
            pipe_hold = m_stall && PIPE_VALID;
        end
        PIPE_VALID = 0; ISSUE_VALID = 0;
        for (int k = 0; k < 20 && LL_VALID; k++) begin
            tick();
            if (last_hs) LL_VALID = 0;
        end
        check("rand_ll_flush", LL_VALID, 0);
        idle_inputs();

        // Reset mid-run with three entries queued and BUSY = 0x88
        RST_N = 0;
        tick();
        RST_N = 1;
        pend_ret.delete();
        PIPE_VALID = 1; PIPE_RD_NUM = 20; PIPE_DATA = 32'h300;
        ISSUE_VALID = 1; ISSUE_RD_NUM = 3;
        tick();
        ISSUE_RD_NUM = 7;
        tick();
        ISSUE_VALID = 0;
        LL_VALID = 1;
        LL_RD_NUM = 3; LL_DATA = 32'h33; tick();
        LL_RD_NUM = 7; LL_DATA = 32'h77; tick();
        LL_RD_NUM = 0; LL_DATA = 32'h00; tick();
        LL_VALID = 0;
        check("pre_rst_busy", BUSY, 32'h88);
        RST_N = 0;
        PIPE_VALID = 0;
        tick();
        check("midrst_wen", WEN, 0);
        check("midrst_busy", BUSY, 0);
        check("midrst_ll_ready", LL_READY, 1);
        RST_N = 1;
        tick();
        check("post_rst_wen", WEN, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
